// File: rtl/segment_pkg.sv
// Shared definitions for the stacker-game segment display path.
//   - Segment patterns are {dp,g,f,e,d,c,b,a}, active-high.
//   - digit_glyph(): decimal digit 0..9 -> segment pattern (other values blank).
//   - tier_glyph():  game level -> tier marker pattern.
//   - scan_state_e:  IDLE / SCAN / FLASH controller states.
package segment_pkg;

  localparam logic [7:0] BLANK = 8'h00;

  localparam logic [7:0] GLYPH_0 = 8'h3F;
  localparam logic [7:0] GLYPH_1 = 8'h06;
  localparam logic [7:0] GLYPH_2 = 8'h5B;
  localparam logic [7:0] GLYPH_3 = 8'h4F;
  localparam logic [7:0] GLYPH_4 = 8'h66;
  localparam logic [7:0] GLYPH_5 = 8'h6D;
  localparam logic [7:0] GLYPH_6 = 8'h7D;
  localparam logic [7:0] GLYPH_7 = 8'h07;
  localparam logic [7:0] GLYPH_8 = 8'h7F;
  localparam logic [7:0] GLYPH_9 = 8'h6F;

  localparam logic [7:0] TIER_LOW_GLYPH  = 8'h0B;
  localparam logic [7:0] TIER_MID_GLYPH  = 8'hDD;
  localparam logic [7:0] TIER_HIGH_GLYPH = 8'h9F;
  localparam logic [7:0] TIER_TOP_GLYPH  = 8'h08;

  // Inclusive upper level bound of each tier; anything above HIGH is TOP.
  localparam logic [3:0] TIER_LOW_MAX  = 4'd3;
  localparam logic [3:0] TIER_MID_MAX  = 4'd5;
  localparam logic [3:0] TIER_HIGH_MAX = 4'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLASH = 2'd2
  } scan_state_e;

  function automatic logic [7:0] digit_glyph(input logic [3:0] value);
    logic [7:0] g;
    case (value)
      4'd0:    g = GLYPH_0;
      4'd1:    g = GLYPH_1;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      4'd9:    g = GLYPH_9;
      default: g = BLANK;
    endcase
    return g;
  endfunction

  function automatic logic [7:0] tier_glyph(input logic [3:0] lvl);
    logic [7:0] g;
    if (lvl <= TIER_LOW_MAX)       g = TIER_LOW_GLYPH;
    else if (lvl <= TIER_MID_MAX)  g = TIER_MID_GLYPH;
    else if (lvl <= TIER_HIGH_MAX) g = TIER_HIGH_GLYPH;
    else                           g = TIER_TOP_GLYPH;
    return g;
  endfunction

endpackage

// File: rtl/segment_glyph_rom.sv
// Combinational glyph lookup: (level, digit position) -> segment pattern.
//   level     in  4      game level 0..15
//   digit_idx in  IDX_W  digit position (0 = ones, 1 = tens, 2 = tier, 3+ = blank)
//   pattern   out 8      {dp,g,f,e,d,c,b,a}, active-high
// Shared by every block that drives the segment bus.
module segment_glyph_rom
  import segment_pkg::*;
#(
  parameter int unsigned IDX_W = 2
) (
  input  logic [3:0]       level,
  input  logic [IDX_W-1:0] digit_idx,
  output logic [7:0]       pattern
);

  logic [3:0] ones;
  logic       has_tens;

  always_comb begin
    has_tens = (level >= 4'd10);
    ones     = has_tens ? (level - 4'd10) : level;
    pattern  = BLANK;
    if (digit_idx == IDX_W'(0)) begin
      pattern = digit_glyph(ones);
    end else if (digit_idx == IDX_W'(1)) begin
      // Leading zero suppressed: tens position is dark below 10.
      pattern = has_tens ? digit_glyph(4'd1) : BLANK;
    end else if (digit_idx == IDX_W'(2)) begin
      pattern = tier_glyph(level);
    end
  end

endmodule

// File: rtl/segment_scan_controller.sv
// Multiplexed segment display controller for the stacker game.
//   clock    in  1           system clock
//   reset    in  1           synchronous, active-high reset
//   enable   in  1           1 = display active, 0 = blank and hold idle
//   level    in  4           current game level 0..15
//   seg_bits out 8           segment pattern {dp,g,f,e,d,c,b,a}, active-high
//   digit_en out NUM_DIGITS  one-hot digit select; all-zero = blank
//   flashing out 1           high while a level-change flash sequence runs
// Each digit is driven for SLOT_CYCLES clocks, with the first cycle of every
// slot blanked to avoid ghosting. A level change flashes the whole display
// FLASH_COUNT times (off phase first) while the scan keeps running.
module segment_scan_controller
  import segment_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SLOT_CYCLES  = 50000,
  parameter int unsigned FLASH_CYCLES = 25000000,
  parameter int unsigned FLASH_COUNT  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [3:0]            level,
  output logic [7:0]            seg_bits,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  flashing
);

  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned SLOT_W  = ($clog2(SLOT_CYCLES) > 0) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned FLASH_W = ($clog2(FLASH_CYCLES) > 0) ? $clog2(FLASH_CYCLES) : 1;
  localparam int unsigned PHASE_W = ($clog2(2 * FLASH_COUNT) > 0) ? $clog2(2 * FLASH_COUNT) : 1;

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(2 * FLASH_COUNT - 1);

  scan_state_e          state_q, state_d;
  logic [SLOT_W-1:0]    slot_cnt, slot_d;
  logic [IDX_W-1:0]     digit_idx, idx_d;
  logic [FLASH_W-1:0]   flash_timer, timer_d;
  logic [PHASE_W-1:0]   flash_phase, phase_d;
  logic [3:0]           level_q;

  logic [7:0]            rom_pattern;
  logic [7:0]            seg_d;
  logic [NUM_DIGITS-1:0] en_d;
  logic [NUM_DIGITS-1:0] onehot;
  logic                  flashing_d;
  logic                  level_changed;
  logic                  show;
  logic                  gated;

  segment_glyph_rom #(
    .IDX_W(IDX_W)
  ) u_glyph_rom (
    .level    (level_q),
    .digit_idx(digit_idx),
    .pattern  (rom_pattern)
  );

  // Next-state and counter logic.
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_cnt;
    idx_d         = digit_idx;
    timer_d       = flash_timer;
    phase_d       = flash_phase;
    level_changed = (level != level_q);

    if (!enable) begin
      state_d = IDLE;
      slot_d  = '0;
      idx_d   = '0;
      timer_d = '0;
      phase_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SCAN;
        end
        SCAN, FLASH: begin
          if (slot_cnt == SLOT_LAST) begin
            slot_d = '0;
            idx_d  = (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
          end else begin
            slot_d = slot_cnt + SLOT_W'(1);
          end

          if (level_changed) begin
            // Any change, including one mid-flash, restarts from the off phase.
            state_d = FLASH;
            timer_d = '0;
            phase_d = '0;
          end else if (state_q == FLASH) begin
            if (flash_timer == FLASH_LAST) begin
              timer_d = '0;
              if (flash_phase == PHASE_LAST) begin
                state_d = SCAN;
                phase_d = '0;
              end else begin
                phase_d = flash_phase + PHASE_W'(1);
              end
            end else begin
              timer_d = flash_timer + FLASH_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output values registered at the next edge. Content and anti-ghost blanking
  // follow the current counters (one cycle latency); idle blanking, flash
  // gating and the flashing flag follow the next state so they line up with
  // the state the controller is entering.
  always_comb begin
    onehot     = NUM_DIGITS'(1) << digit_idx;
    show       = (state_q != IDLE) && (state_d != IDLE);
    gated      = (state_d == FLASH) && !phase_d[0];
    seg_d      = show ? rom_pattern : BLANK;
    en_d       = (show && (slot_cnt != '0) && !gated) ? onehot : '0;
    flashing_d = (state_d == FLASH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      slot_cnt    <= '0;
      digit_idx   <= '0;
      flash_timer <= '0;
      flash_phase <= '0;
      level_q     <= '0;
      seg_bits    <= '0;
      digit_en    <= '0;
      flashing    <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_cnt    <= slot_d;
      digit_idx   <= idx_d;
      flash_timer <= timer_d;
      flash_phase <= phase_d;
      level_q     <= level;
      seg_bits    <= seg_d;
      digit_en    <= en_d;
      flashing    <= flashing_d;
    end
  end

endmodule

// File: tb/tb_segment_scan_controller.sv
// Directed bench for segment_scan_controller with SLOT_CYCLES=4,
// FLASH_CYCLES=8, FLASH_COUNT=2, NUM_DIGITS=4.
// k counts posedges since the edge that moved the DUT from IDLE to SCAN
// (that edge is k=1); the output sampled after edge k shows slot (k-2)%4 of
// digit ((k-2)/4)%4, with the first cycle of each slot blank.
module tb_segment_scan_controller;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [3:0] level;
  logic [7:0] seg_bits;
  logic [3:0] digit_en;
  logic       flashing;

  int total;
  int bad;
  int k;
  logic [7:0] pat [4];

  segment_scan_controller #(
    .NUM_DIGITS  (4),
    .SLOT_CYCLES (4),
    .FLASH_CYCLES(8),
    .FLASH_COUNT (2)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .level   (level),
    .seg_bits(seg_bits),
    .digit_en(digit_en),
    .flashing(flashing)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    k++;
  endtask

  function automatic logic [7:0] exp_seg(input int kk);
    if (kk < 2) return 8'h00;
    return pat[((kk - 2) / 4) % 4];
  endfunction

  function automatic logic [3:0] exp_en(input int kk);
    logic [3:0] one;
    int s;
    int d;
    one = 4'b0001;
    if (kk < 2) return 4'b0000;
    s = (kk - 2) % 4;
    d = ((kk - 2) / 4) % 4;
    if (s == 0) return 4'b0000;
    return one << d;
  endfunction

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; level = 4'd5;
    pat = '{8'h6D, 8'h00, 8'hDD, 8'h00};
    repeat (3) begin
      tick();
      total++;
      if (seg_bits !== 8'h00 || digit_en !== 4'b0000 || flashing !== 1'b0) begin
        $display("FAIL reset_hold got seg=%h en=%b fl=%b want seg=00 en=0000 fl=0",
                 seg_bits, digit_en, flashing);
        bad++;
      end
    end
    @(negedge clock);
    reset = 1'b0;
    k = 0;
    tick();
    total++;
    if (seg_bits !== 8'h00 || digit_en !== 4'b0000 || flashing !== 1'b0) begin
      $display("FAIL reset_idle got seg=%h en=%b fl=%b want all zero", seg_bits, digit_en, flashing);
      bad++;
    end
    repeat (16) begin
      tick();
      total++;
      if (seg_bits !== exp_seg(k) || digit_en !== exp_en(k) || flashing !== 1'b0) begin
        $display("FAIL reset_scan k=%0d got seg=%h en=%b fl=%b want seg=%h en=%b fl=0",
                 k, seg_bits, digit_en, flashing, exp_seg(k), exp_en(k));
        bad++;
      end
    end
  endtask

  task automatic test_steady(input logic [3:0] lvl, input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] p2);
    @(negedge clock);
    enable = 1'b0;
    level  = lvl;
    tick();
    tick();
    @(negedge clock);
    enable = 1'b1;
    k = 0;
    pat = '{p0, p1, p2, 8'h00};
    tick();
    total++;
    if (seg_bits !== 8'h00 || digit_en !== 4'b0000) begin
      $display("FAIL steady_entry lvl=%0d got seg=%h en=%b want 00/0000", lvl, seg_bits, digit_en);
      bad++;
    end
    repeat (16) begin
      tick();
      total++;
      if (seg_bits !== exp_seg(k) || digit_en !== exp_en(k) || flashing !== 1'b0) begin
        $display("FAIL steady lvl=%0d k=%0d got seg=%h en=%b fl=%b want seg=%h en=%b fl=0",
                 lvl, k, seg_bits, digit_en, flashing, exp_seg(k), exp_en(k));
        bad++;
      end
    end
  endtask

  task automatic test_flash();
    @(negedge clock);
    level = 4'd4;
    pat = '{8'h66, 8'h00, 8'hDD, 8'h00};
    for (int j = 0; j < 32; j++) begin
      tick();
      total++;
      if (flashing !== 1'b1) begin
        $display("FAIL flash_flag j=%0d got=%b want=1", j, flashing);
        bad++;
      end
      total++;
      if (((j / 8) % 2) == 0) begin
        if (digit_en !== 4'b0000) begin
          $display("FAIL flash_off j=%0d got en=%b want 0000", j, digit_en);
          bad++;
        end
      end else if (digit_en !== exp_en(k) || seg_bits !== exp_seg(k)) begin
        $display("FAIL flash_on j=%0d got seg=%h en=%b want seg=%h en=%b",
                 j, seg_bits, digit_en, exp_seg(k), exp_en(k));
        bad++;
      end
    end
    repeat (16) begin
      tick();
      total++;
      if (seg_bits !== exp_seg(k) || digit_en !== exp_en(k) || flashing !== 1'b0) begin
        $display("FAIL flash_after k=%0d got seg=%h en=%b fl=%b want seg=%h en=%b fl=0",
                 k, seg_bits, digit_en, flashing, exp_seg(k), exp_en(k));
        bad++;
      end
    end
  endtask

  task automatic test_flash_restart();
    @(negedge clock);
    level = 4'd9;
    pat = '{8'h6F, 8'h00, 8'h08, 8'h00};
    for (int j = 0; j < 10; j++) begin
      tick();
      total++;
      if (flashing !== 1'b1 || digit_en !== ((j < 8) ? 4'b0000 : exp_en(k))) begin
        $display("FAIL restart_first j=%0d got fl=%b en=%b want fl=1 en=%b",
                 j, flashing, digit_en, (j < 8) ? 4'b0000 : exp_en(k));
        bad++;
      end
    end
    @(negedge clock);
    level = 4'd7;
    pat = '{8'h07, 8'h00, 8'h9F, 8'h00};
    for (int j = 0; j < 33; j++) begin
      logic [3:0] want_en;
      logic       want_fl;
      tick();
      want_fl = (j < 32);
      want_en = (j < 32 && ((j / 8) % 2) == 0) ? 4'b0000 : exp_en(k);
      total++;
      if (flashing !== want_fl || digit_en !== want_en) begin
        $display("FAIL restart_seq j=%0d got fl=%b en=%b want fl=%b en=%b",
                 j, flashing, digit_en, want_fl, want_en);
        bad++;
      end
      if (j >= 1 && want_en != 4'b0000) begin
        total++;
        if (seg_bits !== exp_seg(k)) begin
          $display("FAIL restart_seg j=%0d got=%h want=%h", j, seg_bits, exp_seg(k));
          bad++;
        end
      end
    end
  endtask

  task automatic test_disable();
    for (int n = 0; n < 16 && (k % 16) != 11; n++) tick();
    total++;
    if (digit_en !== 4'b0100 || seg_bits !== 8'h9F) begin
      $display("FAIL disable_pre k=%0d got seg=%h en=%b want seg=9f en=0100", k, seg_bits, digit_en);
      bad++;
    end
    @(negedge clock);
    enable = 1'b0;
    level  = 4'd2;
    repeat (3) begin
      tick();
      total++;
      if (seg_bits !== 8'h00 || digit_en !== 4'b0000 || flashing !== 1'b0) begin
        $display("FAIL disable_idle got seg=%h en=%b fl=%b want all zero", seg_bits, digit_en, flashing);
        bad++;
      end
    end
    @(negedge clock);
    enable = 1'b1;
    k = 0;
    pat = '{8'h5B, 8'h00, 8'h0B, 8'h00};
    repeat (9) begin
      tick();
      total++;
      if (seg_bits !== exp_seg(k) || digit_en !== exp_en(k) || flashing !== 1'b0) begin
        $display("FAIL reenable k=%0d got seg=%h en=%b fl=%b want seg=%h en=%b fl=0",
                 k, seg_bits, digit_en, flashing, exp_seg(k), exp_en(k));
        bad++;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    k     = 0;
    reset = 1'b1;
    enable = 1'b0;
    level = 4'd0;
    test_reset();
    test_steady(4'd12, 8'h5B, 8'h06, 8'h08);
    test_steady(4'd3, 8'h4F, 8'h00, 8'h0B);
    test_flash();
    test_flash_restart();
    test_disable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
